rr_mux_arbiter_4: RTL

//   Round-robin arbiter and scheduler for a shared 4:1 data mux.
//   - Four requesters each offer a WIDTH-bit word on a valid/ready handshake.
//   - The block picks one requester per cycle, steers the 4:1 mux by array

---
 rtl/mux_arb_pkg.sv | 22 ++
 rtl/rr_arbiter_4.sv | 35 +++
 rtl/rr_mux_arbiter_4.sv | 99 +++++++++
 3 files changed

// File: rtl/mux_arb_pkg.sv
// ============================================================================
// Package : mux_arb_pkg
// Purpose : shared types and constants for the round-robin 4:1 mux arbiter
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mux_arb_pkg;

    localparam int N_REQ = 4;

    typedef logic [1:0] req_idx_t;

    // Output stage occupancy; FULL is exactly out_valid.
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter_4.sv
// ============================================================================
// Module  : rr_arbiter_4
// Purpose : combinational 4-way round-robin pick starting at ptr
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter_4
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  req_idx_t         ptr,
    output logic             gnt_valid,
    output req_idx_t         gnt_idx
);

    req_idx_t cand;

    // Scan from the farthest candidate back to ptr so the nearest match wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = ptr;
        cand      = ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ptr + req_idx_t'(k);
            if (req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rr_mux_arbiter_4.sv
// ============================================================================
// Module  : rr_mux_arbiter_4
// Purpose : round-robin arbitrated 4:1 data mux with a registered output stage
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_mux_arbiter_4
    import mux_arb_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] in_valid,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [N_REQ-1:0] in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output req_idx_t         out_sel
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    req_idx_t         sel_q,   sel_d;
    req_idx_t         ptr_q,   ptr_d;

    logic [WIDTH-1:0] d_arr [N_REQ];
    logic             gnt_valid;
    req_idx_t         gnt_idx;
    logic             load_en;
    logic             accept;

    assign d_arr[0] = d0;
    assign d_arr[1] = d1;
    assign d_arr[2] = d2;
    assign d_arr[3] = d3;

    rr_arbiter_4 u_arb (
        .req       (in_valid),
        .ptr       (ptr_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign load_en = (state_q == ST_EMPTY) || out_ready;
    assign accept  = gnt_valid && load_en;

    // rst_n gating keeps the handshake quiet for the whole reset window.
    always_comb begin
        in_ready = '0;
        if (rst_n && accept) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_EMPTY: if (accept)         state_d = ST_FULL;
            ST_FULL:  if (accept)         state_d = ST_FULL;
                      else if (out_ready) state_d = ST_EMPTY;
            default:                      state_d = ST_EMPTY;
        endcase
        if (accept) begin
            data_d = d_arr[gnt_idx];
            sel_d  = gnt_idx;
            ptr_d  = gnt_idx + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = data_q;
    assign out_sel   = sel_q;

endmodule

`default_nettype wire
